// File: rtl/axi4lite_pkg.sv
// Shared widths, response codes and FSM states for the AXI4-Lite single-outstanding master.
package axi4lite_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;
    localparam int PROT_W = 3;

    typedef enum logic [1:0] {
        RESP_OKAY    = 2'b00,
        RESP_SLVERR  = 2'b10,
        RESP_TIMEOUT = 2'b11
    } resp_e;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        RSP
    } state_e;

    function automatic logic is_busy(input state_e s);
        return (s == WR_REQ) || (s == WR_RESP) || (s == RD_REQ) || (s == RD_RESP);
    endfunction

endpackage

// File: rtl/axi4lite_wdog.sv
// Transaction watchdog: counts cycles while started, flags expiry on the TIMEOUT_CYC-th cycle.
module axi4lite_wdog #(
    parameter int TIMEOUT_CYC = 256
) (
    input  logic ACLK,
    input  logic ARESETN,
    input  logic start,
    input  logic clear,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt;

    // cnt holds the number of busy cycles already completed, so the last allowed cycle sees TIMEOUT_CYC-1.
    assign expired = start && (cnt == CNT_W'(TIMEOUT_CYC - 1));

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (start && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/axi4lite_master.sv
// AXI4-Lite master: accepts one command, runs the AW/W/B or AR/R handshake, returns one response.
module axi4lite_master
    import axi4lite_pkg::*;
#(
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [PROT_W-1:0]        req_prot,
    input  logic [DATA_W-1:0]        req_wdata,
    input  logic [STRB_W-1:0]        req_wstrb,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_write,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic [1:0]               rsp_resp,
    output logic [PROT_W+ADDR_W-1:0] AW,
    output logic                     AWVALID,
    input  logic                     AWREADY,
    output logic [STRB_W+DATA_W-1:0] W,
    output logic                     WVALID,
    input  logic                     WREADY,
    input  logic [1:0]               B,
    input  logic                     BVALID,
    output logic                     BREADY,
    output logic [PROT_W+ADDR_W-1:0] AR,
    output logic                     ARVALID,
    input  logic                     ARREADY,
    input  logic [DATA_W+1:0]        R,
    input  logic                     RVALID,
    output logic                     RREADY
);

    state_e              state;
    logic                cmd_write;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [PROT_W-1:0]   cmd_prot;
    logic [DATA_W-1:0]   cmd_wdata;
    logic [STRB_W-1:0]   cmd_wstrb;
    logic                busy;
    logic                expired;
    logic                completing;

    assign AW = {cmd_prot, cmd_addr};
    assign AR = {cmd_prot, cmd_addr};
    assign W  = {cmd_wstrb, cmd_wdata};

    assign busy = is_busy(state);
    // A response arriving on the last allowed cycle still wins over the abort.
    assign completing = ((state == WR_RESP) && BVALID) || ((state == RD_RESP) && RVALID);

    axi4lite_wdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_wdog (
        .ACLK   (ACLK),
        .ARESETN(ARESETN),
        .start  (busy),
        .clear  (!busy),
        .expired(expired)
    );

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            cmd_write <= 1'b0;
            cmd_addr  <= '0;
            cmd_prot  <= '0;
            cmd_wdata <= '0;
            cmd_wstrb <= '0;
            AWVALID   <= 1'b0;
            WVALID    <= 1'b0;
            BREADY    <= 1'b0;
            ARVALID   <= 1'b0;
            RREADY    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= RESP_OKAY;
        end else if (expired && !completing) begin
            AWVALID   <= 1'b0;
            WVALID    <= 1'b0;
            BREADY    <= 1'b0;
            ARVALID   <= 1'b0;
            RREADY    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_write <= cmd_write;
            rsp_rdata <= '0;
            rsp_resp  <= RESP_TIMEOUT;
            state     <= RSP;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        cmd_write <= req_write;
                        cmd_addr  <= req_addr;
                        cmd_prot  <= req_prot;
                        cmd_wdata <= req_wdata;
                        cmd_wstrb <= req_wstrb;
                        if (req_write) begin
                            AWVALID <= 1'b1;
                            WVALID  <= 1'b1;
                            state   <= WR_REQ;
                        end else begin
                            ARVALID <= 1'b1;
                            state   <= RD_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    if (AWREADY) AWVALID <= 1'b0;
                    if (WREADY)  WVALID  <= 1'b0;
                    if ((!AWVALID || AWREADY) && (!WVALID || WREADY)) begin
                        BREADY <= 1'b1;
                        state  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (BVALID) begin
                        BREADY    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_write <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_resp  <= B;
                        state     <= RSP;
                    end
                end
                RD_REQ: begin
                    if (ARREADY) begin
                        ARVALID <= 1'b0;
                        RREADY  <= 1'b1;
                        state   <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (RVALID) begin
                        RREADY    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_write <= 1'b0;
                        rsp_rdata <= R[DATA_W-1:0];
                        rsp_resp  <= R[DATA_W+1:DATA_W];
                        state     <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/axi4lite_master.md
AXI4LITE_MASTER -- requirements
Module: axi4lite_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 256, meaning cycles allowed from AW/AR issue to B/R before abort.
REQ-002 SHALL have port ACLK  in  1  clock.
REQ-003 SHALL have port ARESETN  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  in  1  command offered.
REQ-005 SHALL have port req_ready  out  1  command accepted.
REQ-006 SHALL have port req_write  in  1  1=write, 0=read.
REQ-007 SHALL have port req_addr  in  10  word address.
REQ-008 SHALL have port req_prot  in  3  protection bits.
REQ-009 SHALL have port req_wdata  in  32  write data.
REQ-010 SHALL have port req_wstrb  in  4  byte strobes.
REQ-011 SHALL have port rsp_valid  out  1  response available.
REQ-012 SHALL have port rsp_ready  in  1  response consumed.
REQ-013 SHALL have port rsp_write  out  1  response belongs to a write.
REQ-014 SHALL have port rsp_rdata  out  32  read data (0 for writes).
REQ-015 SHALL have port rsp_resp  out  2  00 OKAY, 10 SLVERR, 11 timeout.
REQ-016 SHALL have ports AW out 13 {prot,addr}; AWVALID out 1; AWREADY in 1.
REQ-017 SHALL have ports W out 36 {strb,data}; WVALID out 1; WREADY in 1.
REQ-018 SHALL have ports B in 2 response; BVALID in 1; BREADY out 1.
REQ-019 SHALL have ports AR out 13 {prot,addr}; ARVALID out 1; ARREADY in 1.
REQ-020 SHALL have ports R in 34 {resp,data}; RVALID in 1; RREADY out 1.

Function
REQ-021 SHALL implement FSM IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP; one outstanding transaction.
REQ-022 SHALL assert req_ready only in IDLE; on req_valid&&req_ready, register all req fields; go to WR_REQ or RD_REQ next cycle.
REQ-023 SHALL in WR_REQ assert AWVALID and WVALID in the same first cycle; each deasserts on its own VALID&&READY; AW/W stable while VALID is high.
REQ-024 SHALL go WR_REQ->WR_RESP once both AW and W handshakes are complete (same or different cycles).
REQ-025 SHALL hold BREADY=1 in WR_RESP; on BVALID capture B into rsp_resp, rsp_rdata=0, rsp_write=1, go RSP.
REQ-026 SHALL in RD_REQ assert ARVALID until ARREADY, then go RD_RESP.
REQ-027 SHALL hold RREADY=1 in RD_RESP; on RVALID capture R[31:0] to rsp_rdata, R[33:32] to rsp_resp, rsp_write=0, go RSP.
REQ-028 SHALL hold rsp_valid=1 with stable payload in RSP until rsp_ready, then return to IDLE (next req accepted one cycle later).
REQ-029 SHALL count cycles in WR_REQ/WR_RESP/RD_REQ/RD_RESP; on reaching TIMEOUT_CYC, drop all VALID/READY outputs, set rsp_resp=11, rsp_rdata=0, go RSP.
REQ-030 SHALL ignore BVALID/RVALID outside WR_RESP/RD_RESP (BREADY/RREADY low).
REQ-031 SHALL never assert AWVALID/WVALID and ARVALID in the same cycle.

Reset
REQ-032 SHALL on ARESETN low immediately force state IDLE, timeout counter 0, and all outputs 0 except req_ready (1 after release in IDLE).
REQ-033 SHALL on reset mid-transaction discard the transaction with no rsp_valid.

Structure
REQ-034 SHALL take ADDR_W=10, DATA_W=32, STRB_W=4, PROT_W=3, resp codes and the FSM state enum from shared package axi4lite_pkg.
REQ-035 SHALL place the timeout counter in sub-module axi4lite_wdog (start, clear, expired).

Verification
REQ-036 Write addr 0x005, data 0xDEADBEEF, strb 1111, slave READY=1, B=00 -> AW/W high one cycle, rsp_write=1, rsp_resp=00.
REQ-037 Read addr 0x005 after REQ-036 -> ARVALID one cycle, rsp_rdata=0xDEADBEEF, rsp_resp=00.
REQ-038 Write strb 0001, data 0x000000AA to 0x005, then read -> rsp_rdata=0xDEADBEAA.
REQ-039 WREADY held low 3 cycles with AWREADY=1 -> AWVALID drops after 1 cycle, WVALID held 4 cycles, W stable.
REQ-040 TIMEOUT_CYC=8, BVALID never asserted -> rsp_resp=11 exactly 8 cycles after AW issue; reset mid-RD_RESP -> no rsp_valid, all outputs 0.
